// File: rtl/lpc_reg_pkg.sv
// Shared definitions for the LPC/BMC register arbiter: FSM states, register-file
// geometry, the out-of-range read value and the BMC write-protected window.
package lpc_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   localparam int         LPC_REG_NUM  = 32;
   localparam logic [7:0] OOR_RDATA    = 8'hFF;
   localparam logic [7:0] PROT_ADDR_LO = 8'h00;
   localparam logic [7:0] PROT_ADDR_HI = 8'h07;

   // Offset form keeps the lower bound a real comparison even when it is zero.
   function automatic logic addr_in_prot(input logic [7:0] addr);
      logic [7:0] w_ofs;
      w_ofs = addr - PROT_ADDR_LO;
      return (w_ofs <= (PROT_ADDR_HI - PROT_ADDR_LO));
   endfunction

endpackage

// File: rtl/lpc_reg_arb.sv
// Arbitrates LPC host and BMC accesses onto one register-file port, with a
// starvation guard for the BMC. Optional BMC write protection: LPC_REG_ARB_WRPROT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a request; grant and latch the winner's payload
// ST_ACCESS | one-cycle register strobe, read data captured at the end
// ST_RESP   | one-cycle Ack to the owner, RData valid
module lpc_reg_arb
   import lpc_reg_pkg::*;
#(
   parameter int         STARVE_LIMIT = 4,
   parameter logic [7:0] ADDR_MAX     = 8'(LPC_REG_NUM - 1)
) (
   input  logic       LpcClock,
   input  logic       PciReset,
   input  logic       LpcReq,
   input  logic       LpcWrite,
   input  logic [7:0] LpcAddr,
   input  logic [7:0] LpcWData,
   output logic       LpcAck,
   output logic [7:0] LpcRData,
   input  logic       BmcReq,
   input  logic       BmcWrite,
   input  logic [7:0] BmcAddr,
   input  logic [7:0] BmcWData,
   output logic       BmcAck,
   output logic       BmcWrErr,
   output logic [7:0] BmcRData,
   output logic [7:0] RegAddr,
   output logic [7:0] RegWData,
   output logic       RegWr,
   output logic       RegRd,
   input  logic [7:0] RegRData,
   output logic       ArbBusy
);

   localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_e    r_state;
   logic [SW-1:0] r_starve;
   logic          r_own_bmc;
   logic          r_wr;
   logic [7:0]    r_addr;
   logic [7:0]    r_wdata;
   logic [7:0]    r_lpc_rdata;
   logic [7:0]    r_bmc_rdata;

   logic       w_any_req;
   logic       w_grant_bmc;
   logic       w_in_range;
   logic       w_prot;
   logic       w_access;
   logic       w_resp;
   logic [7:0] w_cap;

   assign w_any_req   = LpcReq | BmcReq;
   assign w_grant_bmc = BmcReq & (~LpcReq | (r_starve == STARVE_MAX));
   assign w_in_range  = (r_addr <= ADDR_MAX);
   assign w_access    = (r_state == ST_ACCESS);
   assign w_resp      = (r_state == ST_RESP);
   assign w_cap       = w_in_range ? RegRData : OOR_RDATA;

`ifdef LPC_REG_ARB_WRPROT_EN
   assign w_prot = r_own_bmc & r_wr & addr_in_prot(r_addr);
`else
   assign w_prot = 1'b0;
`endif

   assign RegAddr  = r_addr;
   assign RegWData = r_wdata;
   assign RegWr    = w_access & r_wr & w_in_range & ~w_prot;
   assign RegRd    = w_access & ~r_wr & w_in_range;
   assign LpcAck   = w_resp & ~r_own_bmc;
   assign BmcAck   = w_resp & r_own_bmc;
   assign BmcWrErr = BmcAck & w_prot;
   assign LpcRData = r_lpc_rdata;
   assign BmcRData = r_bmc_rdata;
   assign ArbBusy  = (r_state != ST_IDLE);

   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         r_state   <= ST_IDLE;
         r_own_bmc <= 1'b0;
         r_wr      <= 1'b0;
         r_addr    <= 8'h00;
         r_wdata   <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state   <= ST_ACCESS;
                  r_own_bmc <= w_grant_bmc;
                  r_wr      <= w_grant_bmc ? BmcWrite : LpcWrite;
                  r_addr    <= w_grant_bmc ? BmcAddr  : LpcAddr;
                  r_wdata   <= w_grant_bmc ? BmcWData : LpcWData;
               end
            end
            ST_ACCESS: r_state <= ST_RESP;
            ST_RESP:   r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // Counts LPC wins only while the BMC is actually waiting.
   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         r_starve <= '0;
      end else if (!BmcReq) begin
         r_starve <= '0;
      end else if (r_state == ST_IDLE && w_any_req) begin
         if (w_grant_bmc) begin
            r_starve <= '0;
         end else if (r_starve != STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end

   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         r_lpc_rdata <= 8'h00;
         r_bmc_rdata <= 8'h00;
      end else if (w_access) begin
         if (r_own_bmc) begin
            r_bmc_rdata <= w_cap;
         end else begin
            r_lpc_rdata <= w_cap;
         end
      end
   end

endmodule

// File: tb/tb_lpc_reg_arb.sv
// Scoreboard bench for lpc_reg_arb; honours LPC_REG_ARB_WRPROT_EN when defined.
module tb_lpc_reg_arb;

   logic       LpcClock = 1'b0;
   logic       PciReset;
   logic       LpcReq, LpcWrite;
   logic [7:0] LpcAddr, LpcWData;
   logic       LpcAck;
   logic [7:0] LpcRData;
   logic       BmcReq, BmcWrite;
   logic [7:0] BmcAddr, BmcWData;
   logic       BmcAck, BmcWrErr;
   logic [7:0] BmcRData;
   logic [7:0] RegAddr, RegWData;
   logic       RegWr, RegRd;
   logic [7:0] RegRData;
   logic       ArbBusy;

   lpc_reg_arb #(.STARVE_LIMIT(4), .ADDR_MAX(8'h1F)) dut (
      .LpcClock(LpcClock), .PciReset(PciReset),
      .LpcReq(LpcReq), .LpcWrite(LpcWrite), .LpcAddr(LpcAddr), .LpcWData(LpcWData),
      .LpcAck(LpcAck), .LpcRData(LpcRData),
      .BmcReq(BmcReq), .BmcWrite(BmcWrite), .BmcAddr(BmcAddr), .BmcWData(BmcWData),
      .BmcAck(BmcAck), .BmcWrErr(BmcWrErr), .BmcRData(BmcRData),
      .RegAddr(RegAddr), .RegWData(RegWData), .RegWr(RegWr), .RegRd(RegRd),
      .RegRData(RegRData), .ArbBusy(ArbBusy)
   );

   always #5 LpcClock = ~LpcClock;

   typedef struct {
      logic       bmc;
      logic [7:0] rdata;
      logic       chk;
      logic       wrerr;
   } ack_t;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
   } stb_t;

   ack_t ack_q[$];
   stb_t stb_q[$];
   ack_t mon_a;
   stb_t mon_s;

   int n_tests = 0;
   int n_fail  = 0;

   logic       load_mem;
   logic [7:0] mem [0:31];

   function automatic logic [7:0] init_val(input int i);
      case (i)
         1:       return 8'h11;
         2:       return 8'h22;
         5:       return 8'h77;
         7:       return 8'h9E;
         11:      return 8'h5A;
         default: return 8'(8'h40 + i);
      endcase
   endfunction

   assign RegRData = mem[RegAddr[4:0]];

   always @(posedge LpcClock) begin
      if (load_mem) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      end else if (RegWr) begin
         mem[RegAddr[4:0]] <= RegWData;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe and every Ack must match the next queued expectation.
   always @(negedge LpcClock) begin
      if (RegWr || RegRd) begin
         if (stb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: actual wr=%0b rd=%0b addr=%0h required none",
                     RegWr, RegRd, RegAddr);
         end else begin
            mon_s = stb_q.pop_front();
            check("strobe_kind", {30'd0, RegWr, RegRd}, {30'd0, mon_s.wr, ~mon_s.wr});
            check("strobe_addr", 32'(RegAddr), 32'(mon_s.addr));
            if (mon_s.wr) check("strobe_wdata", 32'(RegWData), 32'(mon_s.wdata));
         end
      end
      if (LpcAck || BmcAck) begin
         if (ack_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: actual lpc=%0b bmc=%0b required none", LpcAck, BmcAck);
         end else begin
            mon_a = ack_q.pop_front();
            check("ack_owner", {30'd0, LpcAck, BmcAck}, mon_a.bmc ? 32'd1 : 32'd2);
            if (mon_a.chk)
               check("rdata", 32'(mon_a.bmc ? BmcRData : LpcRData), 32'(mon_a.rdata));
            check("wrerr", 32'(BmcWrErr), 32'(mon_a.wrerr));
         end
      end else if (BmcWrErr) begin
         n_tests++;
         n_fail++;
         $display("FAIL wrerr_without_ack: actual 1 required 0");
      end
   end

   task automatic access(input bit bmc, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit exp_stb,
                         input logic [7:0] exp_rdata, input bit chk, input bit exp_err);
      int  cnt;
      bit  got;
      stb_t s;
      ack_t a;
      s.wr = wr; s.addr = addr; s.wdata = wdata;
      a.bmc = bmc; a.rdata = exp_rdata; a.chk = chk; a.wrerr = exp_err;
      if (exp_stb) stb_q.push_back(s);
      ack_q.push_back(a);
      @(negedge LpcClock);
      if (bmc) begin
         BmcReq = 1'b1; BmcWrite = wr; BmcAddr = addr; BmcWData = wdata;
      end else begin
         LpcReq = 1'b1; LpcWrite = wr; LpcAddr = addr; LpcWData = wdata;
      end
      cnt = 0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge LpcClock);
         cnt++;
         if (bmc ? BmcAck : LpcAck) got = 1'b1;
      end
      check(bmc ? "bmc_latency" : "lpc_latency", 32'(cnt), 32'd2);
      LpcReq = 1'b0;
      BmcReq = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      stb_t s;
      ack_t a;
      PciReset = 1'b0; load_mem = 1'b1;
      LpcReq = 1'b0; LpcWrite = 1'b0; LpcAddr = 8'h00; LpcWData = 8'h00;
      BmcReq = 1'b0; BmcWrite = 1'b0; BmcAddr = 8'h00; BmcWData = 8'h00;
      repeat (2) @(negedge LpcClock);
      check("rst_busy",   32'(ArbBusy), 32'd0);
      check("rst_acks",   {29'd0, LpcAck, BmcAck, BmcWrErr}, 32'd0);
      check("rst_strobe", {30'd0, RegWr, RegRd}, 32'd0);
      check("rst_regbus", {16'd0, RegAddr, RegWData}, 32'd0);
      check("rst_rdata",  {16'd0, LpcRData, BmcRData}, 32'd0);
      load_mem = 1'b0;
      PciReset = 1'b1;

      // LPC read, write and read-back
      access(0, 0, 8'h0B, 8'h00, 1, 8'h5A, 1, 0);
      access(0, 1, 8'h10, 8'hC3, 1, 8'h00, 0, 0);
      access(0, 0, 8'h10, 8'h00, 1, 8'hC3, 1, 0);

      // BMC in-range read, out-of-range write and read
      access(1, 0, 8'h07, 8'h00, 1, 8'h9E, 1, 0);
      access(1, 1, 8'h25, 8'h33, 0, 8'h00, 0, 0);
      access(1, 0, 8'h25, 8'h00, 0, 8'hFF, 1, 0);
      check("lpc_rdata_hold", 32'(LpcRData), 32'h0000_00C3);

      // BMC write into the protected window
`ifdef LPC_REG_ARB_WRPROT_EN
      access(1, 1, 8'h04, 8'h1B, 0, 8'h00, 0, 1);
      access(1, 0, 8'h04, 8'h00, 1, 8'h44, 1, 0);
`else
      access(1, 1, 8'h04, 8'h1B, 1, 8'h00, 0, 0);
      access(1, 0, 8'h04, 8'h00, 1, 8'h1B, 1, 0);
`endif

      // Both requesters held: L L L L B, twice
      for (int k = 0; k < 10; k++) begin
         s.wr = 1'b0;
         s.addr = (k % 5 == 4) ? 8'h02 : 8'h01;
         s.wdata = 8'h00;
         a.bmc = (k % 5 == 4);
         a.rdata = (k % 5 == 4) ? 8'h22 : 8'h11;
         a.chk = 1'b1;
         a.wrerr = 1'b0;
         stb_q.push_back(s);
         ack_q.push_back(a);
      end
      @(negedge LpcClock);
      LpcReq = 1'b1; LpcWrite = 1'b0; LpcAddr = 8'h01;
      BmcReq = 1'b1; BmcWrite = 1'b0; BmcAddr = 8'h02;
      n = 0;
      for (int i = 0; i < 60 && n < 10; i++) begin
         @(negedge LpcClock);
         if (LpcAck || BmcAck) n++;
      end
      LpcReq = 1'b0;
      BmcReq = 1'b0;
      check("starve_ack_count", 32'(n), 32'd10);

      // Reset during ACCESS drops the LPC write
      @(negedge LpcClock);
      LpcReq = 1'b1; LpcWrite = 1'b1; LpcAddr = 8'h03; LpcWData = 8'hEE;
      @(posedge LpcClock);
      #1 PciReset = 1'b0;
      @(negedge LpcClock);
      check("rstmid_busy",   32'(ArbBusy), 32'd0);
      check("rstmid_signal", {29'd0, RegWr, RegRd, LpcAck}, 32'd0);
      check("rstmid_rdata",  32'(LpcRData), 32'd0);
      LpcReq = 1'b0;
      @(negedge LpcClock);
      PciReset = 1'b1;
      access(0, 0, 8'h03, 8'h00, 1, 8'h43, 1, 0);

      repeat (3) @(negedge LpcClock);
      check("ack_q_empty", 32'(ack_q.size()), 32'd0);
      check("stb_q_empty", 32'(stb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lpc_reg_arb.md
LPC_REG_ARB -- requirements
Module: lpc_reg_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive LPC grants with BmcReq pending before the BMC is forced a grant.
REQ-002 SHALL have parameter ADDR_MAX, default 8'h1F: highest implemented register address.
REQ-003 SHALL have port LpcClock, input, 1: clock.
REQ-004 SHALL have port PciReset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports LpcReq, LpcWrite (input, 1), LpcAddr, LpcWData (input, 8): host request level, write flag, address, write data.
REQ-006 SHALL have ports LpcAck (output, 1) and LpcRData (output, 8): host completion pulse and read data.
REQ-007 SHALL have ports BmcReq, BmcWrite (input, 1), BmcAddr, BmcWData (input, 8): BMC-side request.
REQ-008 SHALL have ports BmcAck, BmcWrErr (output, 1) and BmcRData (output, 8): BMC completion, write-rejected flag, read data.
REQ-009 SHALL have ports RegAddr, RegWData (output, 8) and RegWr, RegRd (output, 1): register-file access strobes.
REQ-010 SHALL have port RegRData, input, 8: combinational read of the register at RegAddr.
REQ-011 SHALL have port ArbBusy, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; ACCESS and RESP last exactly one cycle each.
REQ-013 SHALL, in IDLE with any request high, latch owner, write flag, address and data, and move to ACCESS on the same edge.
REQ-014 SHALL, when both requests are high in IDLE, grant LPC unless the starve counter equals STARVE_LIMIT, in which case grant BMC.
REQ-015 SHALL increment the saturating starve counter on each LPC grant made while BmcReq is high, and clear it on a BMC grant or while BmcReq is low.
REQ-016 SHALL, in ACCESS, drive RegAddr/RegWData from latches and assert exactly one of RegWr or RegRd for exactly one cycle; RegWr/RegRd are low in all other states.
REQ-017 SHALL suppress RegWr and RegRd when the latched address exceeds ADDR_MAX; such reads return 8'hFF, and such writes are discarded and still acknowledged.
REQ-018 SHALL capture RegRData at the end of ACCESS and present it on the owner's RData in RESP, holding it until that owner's next RESP.
REQ-019 SHALL pulse the owner's Ack for exactly the RESP cycle; latency is request sampled at edge N, strobe in cycle N+1, Ack in cycle N+2.
REQ-020 SHALL rely on the requester holding Req and its payload until Ack and dropping Req in the cycle after Ack; payload changes after the grant edge are ignored.
REQ-021 SHALL allow a new grant in the IDLE cycle immediately following RESP, giving a maximum throughput of one access per 3 cycles.

Reset
REQ-022 SHALL, while PciReset is low, force FSM=IDLE, starve counter=0, all Ack/strobes/BmcWrErr/ArbBusy=0, RegAddr=RegWData=8'h00, and LpcRData=BmcRData=8'h00.
REQ-023 SHALL drop any in-flight access on reset without Ack and without a strobe.

Configuration
REQ-024 SHALL, with LPC_REG_ARB_WRPROT_EN defined, suppress RegWr for BMC writes to addresses 8'h00-8'h07, complete them with BmcAck, and pulse BmcWrErr together with that BmcAck.
REQ-025 SHALL, without LPC_REG_ARB_WRPROT_EN, pass all in-range BMC writes through and tie BmcWrErr to 0.

Structure
REQ-026 SHALL take the FSM state enum, LPC_REG_NUM=32, the read value for out-of-range addresses (8'hFF) and the protected-range bounds from shared package lpc_reg_pkg.
REQ-027 SHALL implement the block flat, with no sub-module; the starve counter is inline.

Verification
REQ-028 SHALL cover: LPC read 8'h0B with RegRData=8'h5A -> RegRd high for 1 cycle at N+1, LpcAck plus LpcRData=8'h5A at N+2.
REQ-029 SHALL cover: LpcReq and BmcReq held high continuously with STARVE_LIMIT=4 -> 4 LPC grants, then 1 BMC grant, then the counter restarts.
REQ-030 SHALL cover: BMC write to 8'h25 data 8'h33 -> no RegWr, BmcAck after 2 cycles; BMC read to 8'h25 -> BmcRData=8'hFF.
REQ-031 SHALL cover: BMC write to 8'h04 data 8'h1B -> with the macro, no RegWr and BmcWrErr plus BmcAck; without it, RegWr with RegWData=8'h1B.
REQ-032 SHALL cover: PciReset asserted during ACCESS -> strobes and Ack stay low, FSM returns to IDLE, and the next request completes normally.
